seg7_scan: RTL and testbench
============================

Name: seg7_scan

Overview:
- Consumer end of the display-refresh interface: takes the slow refresh square wave from the clock divider and time-multiplexes an 8-digit common-anode 7-segment display.
- Advances one digit per refresh rising edge. Blanks the anodes for a short interval between digits to suppress ghosting.
- Latches the display word once per frame so the display never shows a torn value.
- Sits between the CPU debug/IO register file (data source) and the board display pins.

Parameters:
- NUM_DIGITS, 8, number of digits scanned (2..8); data_i uses 4*NUM_DIGITS LSBs.
- BLANK_CYC, 16, clk_i cycles with all anodes off after each digit change (1..255).

Ports:
- clk_i  in  1  system clock (25 MHz)
- rst  in  1  synchronous active-high reset
- refresh_i  in  1  refresh square wave from the divider; treated as asynchronous
- data_i  in  32  hex digits; digit k = data_i[4k+3:4k]
- dp_i  in  8  decimal point per digit, 1 = lit
- en_i  in  8  digit enable mask, 1 = digit shown
- an_o  out  8  anode selects, active-low, bit k = digit k
- seg_o  out  7  segments {g,f,e,d,c,b,a}, active-low
- dp_o  out  1  decimal point, active-low
- frame_o  out  1  one-cycle pulse when digit 0 is selected and the frame latch updates

Behaviour:
- Reset is synchronous, active-high: rst sampled on posedge clk_i.
  - Reset values: an_o=8'hFF, seg_o=7'h7F, dp_o=1, frame_o=0.
  - Internal reset state: idx=NUM_DIGITS-1, sync flops=0, state=IDLE, latches=0.
- Reset mid-scan returns to IDLE on the next edge with outputs at reset values.
- Input synchronizer and edge detect:
  - refresh_i passes through a 2-flop synchronizer plus one history flop.
  - tick = sync_q & ~hist_q, a one-cycle pulse.
  - tick is asserted in the 3rd clk_i cycle after the refresh_i rising edge.
  - The falling edge of refresh_i has no effect.
- State machine: IDLE, BLANK, DRIVE.
  - IDLE: outputs off. On tick -> BLANK.
  - BLANK: an_o=8'hFF, seg_o=7'h7F, dp_o=1. Blank counter counts BLANK_CYC cycles, then -> DRIVE.
  - DRIVE: an_o[idx]=0 if lat_en[idx], else all anodes off; seg_o=decode(lat_data nibble idx); dp_o=~lat_dp[idx]. Stays in DRIVE until tick -> BLANK.
  - BLANK lasts exactly BLANK_CYC cycles before DRIVE outputs appear; outputs are registered.
  - A tick that arrives during BLANK advances idx and restarts the blank counter; no digit is skipped silently.
- Index and frame latch, on every tick:
  - idx <= (idx==NUM_DIGITS-1) ? 0 : idx+1.
  - When the new idx is 0: latch data_i/dp_i/en_i into lat_*, and pulse frame_o in the same cycle that idx becomes 0.
  - The first tick after reset therefore selects digit 0 and latches.
  - Changes to data_i between frames are invisible until the next digit-0 tick.
- Decoder is combinational from the latched nibble, with the output registered. Active-low values:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- Anode bits at NUM_DIGITS and above are held at 1.

Decomposition:
- Shared package seg7_pkg:
  - SEG_OFF=7'h7F, AN_OFF=8'hFF.
  - State enum {IDLE, BLANK, DRIVE}.
  - Function hex2seg(nibble) returning the active-low pattern above.
- One sub-module, edge_sync: 2-flop synchronizer plus rising-edge pulse. Reused for button inputs elsewhere.

Test Plan:
- Reset and idle: hold rst 3 cycles with refresh_i static -> an_o=FF, seg_o=7F, dp_o=1, frame_o=0 indefinitely.
- First tick:
  - Stimulus: data_i=32'h76543210, en_i=FF, dp_i=00; refresh_i rises.
  - Tick is seen 3 cycles after the edge.
  - frame_o pulses 1 cycle; an_o=FF for 16 cycles; then an_o=FE, seg_o=40, dp_o=1.
- Full scan:
  - 8 further refresh edges -> an_o walks FD, FB, ... 7F, then wraps to FE.
  - seg_o at digit 7 is 78; frame_o pulses on the wrap.
- Tear-free latch:
  - Change data_i to 32'hFFFFFFFF while digit 3 is driving.
  - Digits 4..7 still show 4..7; after the wrap, digit 0 shows 0E.
- Mask and decimal point: en_i=8'h01, dp_i=8'h01 -> digit 0 shows an_o=FE, dp_o=0; digits 1..7 show an_o=FF.
- Edge cases:
  - Two refresh edges 10 cycles apart (inside BLANK): idx advances twice and DRIVE starts 16 cycles after the 2nd tick.
  - rst asserted during DRIVE: next cycle an_o=FF; the next tick selects digit 0 with frame_o=1.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared types, constants and the hex-to-segment decoder for the 7-segment scanner.
package seg7_pkg;

   localparam int unsigned SEG_W = 7;
   localparam int unsigned AN_W  = 8;

   // Active-low "everything dark" values for the segment and anode buses.
   localparam logic [SEG_W-1:0] SEG_OFF = 7'h7F;
   localparam logic [AN_W-1:0]  AN_OFF  = 8'hFF;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BLANK = 2'd1,
      DRIVE = 2'd2
   } state_e;

   // Hex nibble to active-low segment pattern, bit order {g,f,e,d,c,b,a}.
   function automatic logic [SEG_W-1:0] hex2seg(input logic [3:0] nib);
      logic [SEG_W-1:0] seg;
      case (nib)
         4'h0:    seg = 7'h40;
         4'h1:    seg = 7'h79;
         4'h2:    seg = 7'h24;
         4'h3:    seg = 7'h30;
         4'h4:    seg = 7'h19;
         4'h5:    seg = 7'h12;
         4'h6:    seg = 7'h02;
         4'h7:    seg = 7'h78;
         4'h8:    seg = 7'h00;
         4'h9:    seg = 7'h10;
         4'hA:    seg = 7'h08;
         4'hB:    seg = 7'h03;
         4'hC:    seg = 7'h46;
         4'hD:    seg = 7'h21;
         4'hE:    seg = 7'h06;
         default: seg = 7'h0E;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/seg7_scan_edge_sync.sv
// Two-flop synchronizer plus rising-edge detector for slow asynchronous inputs.
module edge_sync (
   input  logic clk_i,
   input  logic rst,
   input  logic sig_i,
   output logic rise_c_o
);

   logic sync1_q;
   logic sync2_q;
   logic hist_q;

   // Synchronizer chain and one history flop for edge detection.
   always_ff @(posedge clk_i) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         hist_q  <= 1'b0;
      end else begin
         sync1_q <= sig_i;
         sync2_q <= sync1_q;
         hist_q  <= sync2_q;
      end
   end

   // One-cycle pulse on a synchronized low-to-high transition.
   assign rise_c_o = sync2_q & ~hist_q;

endmodule

// File: rtl/seg7_scan.sv
// Time-multiplexed driver for a common-anode 7-segment display with inter-digit
// blanking and a per-frame latch of the display word.
module seg7_scan
   import seg7_pkg::*;
#(
   parameter int unsigned NUM_DIGITS = 8,
   parameter int unsigned BLANK_CYC  = 16
) (
   input  logic        clk_i,
   input  logic        rst,
   input  logic        refresh_i,
   input  logic [31:0] data_i,
   input  logic [7:0]  dp_i,
   input  logic [7:0]  en_i,
   output logic [7:0]  an_o,
   output logic [6:0]  seg_o,
   output logic        dp_o,
   output logic        frame_o
);

   localparam int unsigned IDX_W  = 3;
   localparam int unsigned CNT_W  = 8;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned DIG_W  = 8;

   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BLANK_CYC - 1);

   logic tick_c;

   state_e             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [DATA_W-1:0]  lat_data_q, lat_data_d;
   logic [DIG_W-1:0]   lat_dp_q, lat_dp_d;
   logic [DIG_W-1:0]   lat_en_q, lat_en_d;
   logic [AN_W-1:0]    an_q, an_d;
   logic [SEG_W-1:0]   seg_q, seg_d;
   logic               dp_q, dp_d;
   logic               frame_q, frame_d;

   // Refresh square wave crosses into clk_i and becomes a one-cycle tick.
   edge_sync u_refresh_sync (
      .clk_i    (clk_i),
      .rst      (rst),
      .sig_i    (refresh_i),
      .rise_c_o (tick_c)
   );

   // Next-state, index/latch update and next-output decode.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      cnt_d      = cnt_q;
      lat_data_d = lat_data_q;
      lat_dp_d   = lat_dp_q;
      lat_en_d   = lat_en_q;
      frame_d    = 1'b0;
      an_d       = AN_OFF;
      seg_d      = SEG_OFF;
      dp_d       = 1'b1;

      // Every tick advances the digit; wrapping to digit 0 starts a new frame.
      if (tick_c) begin
         idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
         if (idx_d == '0) begin
            lat_data_d = data_i;
            lat_dp_d   = dp_i;
            lat_en_d   = en_i;
            frame_d    = 1'b1;
         end
      end

      case (state_q)
         IDLE: begin
            if (tick_c) begin
               state_d = BLANK;
               cnt_d   = '0;
            end
         end
         BLANK: begin
            // A tick while blanking restarts the blank interval for the new digit.
            if (tick_c) begin
               cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = DRIVE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DRIVE: begin
            if (tick_c) begin
               state_d = BLANK;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase

      // DRIVE is only entered without a tick, so idx_q and the latches are stable here.
      if (state_d == DRIVE) begin
         if (lat_en_q[idx_q]) begin
            an_d[idx_q] = 1'b0;
         end
         seg_d = hex2seg(lat_data_q[{idx_q, 2'b00} +: 4]);
         dp_d  = ~lat_dp_q[idx_q];
      end
   end

   // State, latches and registered display outputs.
   always_ff @(posedge clk_i) begin
      if (rst) begin
         state_q    <= IDLE;
         idx_q      <= IDX_LAST;
         cnt_q      <= '0;
         lat_data_q <= '0;
         lat_dp_q   <= '0;
         lat_en_q   <= '0;
         an_q       <= AN_OFF;
         seg_q      <= SEG_OFF;
         dp_q       <= 1'b1;
         frame_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         cnt_q      <= cnt_d;
         lat_data_q <= lat_data_d;
         lat_dp_q   <= lat_dp_d;
         lat_en_q   <= lat_en_d;
         an_q       <= an_d;
         seg_q      <= seg_d;
         dp_q       <= dp_d;
         frame_q    <= frame_d;
      end
   end

   assign an_o    = an_q;
   assign seg_o   = seg_q;
   assign dp_o    = dp_q;
   assign frame_o = frame_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Directed, table-driven bench for seg7_scan.
module tb_seg7_scan;

   logic        clk_i;
   logic        rst;
   logic        refresh_i;
   logic [31:0] data_i;
   logic [7:0]  dp_i;
   logic [7:0]  en_i;
   logic [7:0]  an_o;
   logic [6:0]  seg_o;
   logic        dp_o;
   logic        frame_o;

   int total;
   int bad;

   typedef struct {
      logic [31:0] data;
      logic [7:0]  dpi;
      logic [7:0]  en;
      logic [7:0]  an;
      logic [6:0]  seg;
      logic        dpo;
      logic        frame;
   } vec_t;

   localparam int NV = 19;
   vec_t vecs [NV];

   seg7_scan #(.NUM_DIGITS(8), .BLANK_CYC(16)) dut (
      .clk_i     (clk_i),
      .rst       (rst),
      .refresh_i (refresh_i),
      .data_i    (data_i),
      .dp_i      (dp_i),
      .en_i      (en_i),
      .an_o      (an_o),
      .seg_o     (seg_o),
      .dp_o      (dp_o),
      .frame_o   (frame_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Raise refresh, let the tick land, drop it; returns one cycle after the tick edge.
   task automatic send_edge();
      refresh_i = 1'b1;
      step();
      step();
      step();
      refresh_i = 1'b0;
   endtask

   // Expect exactly 16 dark cycles, then step into the first DRIVE cycle.
   task automatic run_blank(input string nm);
      int errs;
      errs = 0;
      for (int i = 0; i < 16; i++) begin
         if (i > 0) begin
            step();
            if (frame_o !== 1'b0) errs++;
         end
         if (an_o !== 8'hFF || seg_o !== 7'h7F || dp_o !== 1'b1) errs++;
      end
      check({nm, "_blank"}, 32'(errs), 32'd0);
      step();
   endtask

   initial begin
      int errs;
      total     = 0;
      bad       = 0;
      rst       = 1'b1;
      refresh_i = 1'b0;
      data_i    = 32'h0;
      dp_i      = 8'h00;
      en_i      = 8'h00;

      vecs[0]  = '{32'h76543210, 8'h00, 8'hFF, 8'hFE, 7'h40, 1'b1, 1'b1};
      vecs[1]  = '{32'h76543210, 8'h00, 8'hFF, 8'hFD, 7'h79, 1'b1, 1'b0};
      vecs[2]  = '{32'h76543210, 8'h00, 8'hFF, 8'hFB, 7'h24, 1'b1, 1'b0};
      vecs[3]  = '{32'h76543210, 8'h00, 8'hFF, 8'hF7, 7'h30, 1'b1, 1'b0};
      vecs[4]  = '{32'hFFFFFFFF, 8'h00, 8'hFF, 8'hEF, 7'h19, 1'b1, 1'b0};
      vecs[5]  = '{32'hFFFFFFFF, 8'h00, 8'hFF, 8'hDF, 7'h12, 1'b1, 1'b0};
      vecs[6]  = '{32'hFFFFFFFF, 8'h00, 8'hFF, 8'hBF, 7'h02, 1'b1, 1'b0};
      vecs[7]  = '{32'hFFFFFFFF, 8'h00, 8'hFF, 8'h7F, 7'h78, 1'b1, 1'b0};
      vecs[8]  = '{32'hFFFFFFFF, 8'h00, 8'hFF, 8'hFE, 7'h0E, 1'b1, 1'b1};
      vecs[9]  = '{32'h76543210, 8'h01, 8'h01, 8'hFD, 7'h0E, 1'b1, 1'b0};
      vecs[10] = '{32'h76543210, 8'h01, 8'h01, 8'hFB, 7'h0E, 1'b1, 1'b0};
      vecs[11] = '{32'h76543210, 8'h01, 8'h01, 8'hF7, 7'h0E, 1'b1, 1'b0};
      vecs[12] = '{32'h76543210, 8'h01, 8'h01, 8'hEF, 7'h0E, 1'b1, 1'b0};
      vecs[13] = '{32'h76543210, 8'h01, 8'h01, 8'hDF, 7'h0E, 1'b1, 1'b0};
      vecs[14] = '{32'h76543210, 8'h01, 8'h01, 8'hBF, 7'h0E, 1'b1, 1'b0};
      vecs[15] = '{32'h76543210, 8'h01, 8'h01, 8'h7F, 7'h0E, 1'b1, 1'b0};
      vecs[16] = '{32'h76543210, 8'h01, 8'h01, 8'hFE, 7'h40, 1'b0, 1'b1};
      vecs[17] = '{32'h76543210, 8'h01, 8'h01, 8'hFF, 7'h79, 1'b1, 1'b0};
      vecs[18] = '{32'h76543210, 8'h01, 8'h01, 8'hFF, 7'h24, 1'b1, 1'b0};

      // Reset and idle.
      repeat (3) step();
      check("rst_an", 32'(an_o), 32'hFF);
      check("rst_seg", 32'(seg_o), 32'h7F);
      check("rst_dp", 32'(dp_o), 32'd1);
      check("rst_frame", 32'(frame_o), 32'd0);
      rst = 1'b0;
      errs = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (an_o !== 8'hFF || seg_o !== 7'h7F || dp_o !== 1'b1 || frame_o !== 1'b0) errs++;
      end
      check("idle_dark", 32'(errs), 32'd0);

      // Scan, tear-free latch, mask and decimal point.
      for (int v = 0; v < NV; v++) begin
         data_i = vecs[v].data;
         dp_i   = vecs[v].dpi;
         en_i   = vecs[v].en;
         send_edge();
         check($sformatf("v%0d_frame", v), 32'(frame_o), 32'(vecs[v].frame));
         run_blank($sformatf("v%0d", v));
         check($sformatf("v%0d_an", v), 32'(an_o), 32'(vecs[v].an));
         check($sformatf("v%0d_seg", v), 32'(seg_o), 32'(vecs[v].seg));
         check($sformatf("v%0d_dp", v), 32'(dp_o), 32'(vecs[v].dpo));
      end

      // Two refresh edges 10 cycles apart, both inside BLANK.
      rst = 1'b1;
      step();
      step();
      rst    = 1'b0;
      data_i = 32'h76543210;
      dp_i   = 8'h00;
      en_i   = 8'hFF;
      send_edge();
      check("dbl_frame1", 32'(frame_o), 32'd1);
      errs = 0;
      for (int i = 0; i < 7; i++) begin
         step();
         if (an_o !== 8'hFF) errs++;
      end
      check("dbl_gap_dark", 32'(errs), 32'd0);
      send_edge();
      check("dbl_frame2", 32'(frame_o), 32'd0);
      run_blank("dbl");
      check("dbl_an", 32'(an_o), 32'hFD);
      check("dbl_seg", 32'(seg_o), 32'h79);

      // Reset during DRIVE.
      rst = 1'b1;
      step();
      check("rstd_an", 32'(an_o), 32'hFF);
      check("rstd_seg", 32'(seg_o), 32'h7F);
      check("rstd_dp", 32'(dp_o), 32'd1);
      rst = 1'b0;
      step();
      send_edge();
      check("rstd_frame", 32'(frame_o), 32'd1);
      run_blank("rstd");
      check("rstd_an0", 32'(an_o), 32'hFE);
      check("rstd_seg0", 32'(seg_o), 32'h40);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
